// File: rtl/garage_door_actuator.sv
// garage_door_actuator: motorised door controller.
// The door spins the motor up for SPIN_CYCLES, then steps its position one unit per cycle
// between closed (0) and fully open (TRAVEL_CYCLES).
// Opposing commands drive the FSM into FAULT.
// All outputs are registered, and the limit flags track the next position.
// Optional feature macro: OBSTRUCTION_EN adds the Obstruct input and a sticky Obstructed
// output. With it defined, closing stops when an obstruction is seen.
module garage_door_actuator #(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned SPIN_CYCLES   = 2,
  parameter int unsigned POS_W         = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             UP_M,
  input  logic             DN_M,
`ifdef OBSTRUCTION_EN
  input  logic             Obstruct,
  output logic             Obstructed,
`endif
  output logic             UP_Max,
  output logic             DN_Max,
  output logic [POS_W-1:0] Position,
  output logic             Moving,
  output logic             Fault
);

  localparam int unsigned CNT_W = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_TOP   = POS_W'(TRAVEL_CYCLES);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

  localparam logic [2:0] ST_STOPPED = 3'd0;
  localparam logic [2:0] ST_SPIN_UP = 3'd1;
  localparam logic [2:0] ST_SPIN_DN = 3'd2;
  localparam logic [2:0] ST_MOVE_UP = 3'd3;
  localparam logic [2:0] ST_MOVE_DN = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd5;

  logic [2:0]       r_state;
  logic [POS_W-1:0] r_pos;
  logic [CNT_W-1:0] r_cnt;
  logic             r_up_max;
  logic             r_dn_max;
  logic             r_moving;
  logic             r_fault;

  logic [2:0]       w_state_nxt;
  logic [POS_W-1:0] w_pos_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_both;
  logic             w_up_only;
  logic             w_dn_only;
  logic             w_obstruct;
  logic             w_obst_hit;

  assign w_both    = UP_M & DN_M;
  assign w_up_only = UP_M & ~DN_M;
  assign w_dn_only = DN_M & ~UP_M;

`ifdef OBSTRUCTION_EN
  assign w_obstruct = Obstruct;
`else
  assign w_obstruct = 1'b0;
`endif

  // An obstruction only matters while heading down; a fault request still wins.
  assign w_obst_hit = w_obstruct & ~w_both &
                      ((r_state == ST_SPIN_DN) | (r_state == ST_MOVE_DN));

  // Next state, position and spin counter.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_cnt_nxt   = r_cnt;
    if (w_both) begin
      // Conflicting commands fault from anywhere; position is frozen.
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_FAULT: begin
          if (!UP_M && !DN_M) begin
            w_state_nxt = ST_STOPPED;
          end
        end
        ST_STOPPED: begin
          // Commands toward a limit already reached are ignored.
          if (w_up_only && (r_pos < POS_TOP)) begin
            w_state_nxt = ST_SPIN_UP;
            w_cnt_nxt   = '0;
          end else if (w_dn_only && (r_pos != '0) && !w_obstruct) begin
            w_state_nxt = ST_SPIN_DN;
            w_cnt_nxt   = '0;
          end
        end
        ST_SPIN_UP: begin
          if (!w_up_only) begin
            w_state_nxt = ST_STOPPED;
          end else if (r_cnt == SPIN_LAST) begin
            w_state_nxt = ST_MOVE_UP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_SPIN_DN: begin
          if (!w_dn_only || w_obst_hit) begin
            w_state_nxt = ST_STOPPED;
          end else if (r_cnt == SPIN_LAST) begin
            w_state_nxt = ST_MOVE_DN;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_MOVE_UP: begin
          if (!w_up_only) begin
            w_state_nxt = ST_STOPPED;
          end else if (r_pos < POS_TOP) begin
            w_pos_nxt = r_pos + POS_ONE;
            // Stop on the same edge that lands on the upper limit.
            if ((r_pos + POS_ONE) == POS_TOP) begin
              w_state_nxt = ST_STOPPED;
            end
          end else begin
            w_state_nxt = ST_STOPPED;
          end
        end
        ST_MOVE_DN: begin
          if (!w_dn_only || w_obst_hit) begin
            w_state_nxt = ST_STOPPED;
          end else if (r_pos != '0) begin
            w_pos_nxt = r_pos - POS_ONE;
            if (r_pos == POS_ONE) begin
              w_state_nxt = ST_STOPPED;
            end
          end else begin
            w_state_nxt = ST_STOPPED;
          end
        end
        default: begin
          w_state_nxt = ST_STOPPED;
        end
      endcase
    end
  end

  // State, position and spin counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_STOPPED;
      r_pos   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Status outputs are decoded from next-state values so they change with Position.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_up_max <= 1'b0;
      r_dn_max <= 1'b1;
      r_moving <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_up_max <= (w_pos_nxt == POS_TOP);
      r_dn_max <= (w_pos_nxt == '0);
      r_moving <= (w_state_nxt == ST_MOVE_UP) || (w_state_nxt == ST_MOVE_DN);
      r_fault  <= (w_state_nxt == ST_FAULT);
    end
  end

`ifdef OBSTRUCTION_EN
  logic r_obstructed;

  // Sticky obstruction flag, cleared only when a new opening run starts.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_obstructed <= 1'b0;
    end else if ((w_state_nxt == ST_SPIN_UP) && (r_state != ST_SPIN_UP)) begin
      r_obstructed <= 1'b0;
    end else if (w_obst_hit) begin
      r_obstructed <= 1'b1;
    end
  end

  assign Obstructed = r_obstructed;
`endif

  assign UP_Max   = r_up_max;
  assign DN_Max   = r_dn_max;
  assign Position = r_pos;
  assign Moving   = r_moving;
  assign Fault    = r_fault;

endmodule

// File: tb/tb_garage_door_actuator.sv
// tb_garage_door_actuator: scoreboard bench for garage_door_actuator.
// A cycle model predicts outputs as each command is driven; predictions are queued and
// compared one cycle later, after the clock edge. Define OBSTRUCTION_EN to cover that feature.
module tb_garage_door_actuator;

  localparam int unsigned TRAVEL = 8;
  localparam int unsigned SPIN   = 2;
  localparam int unsigned PW     = 8;

  localparam int M_STOP = 0;
  localparam int M_SU   = 1;
  localparam int M_SD   = 2;
  localparam int M_MU   = 3;
  localparam int M_MD   = 4;
  localparam int M_FLT  = 5;

  typedef struct {
    logic [PW-1:0] pos;
    logic          up_max;
    logic          dn_max;
    logic          moving;
    logic          fault;
    logic          obs;
  } exp_t;

  logic          CLK;
  logic          RST;
  logic          UP_M;
  logic          DN_M;
  logic          UP_Max;
  logic          DN_Max;
  logic [PW-1:0] Position;
  logic          Moving;
  logic          Fault;
  logic          tb_obstruct;
`ifdef OBSTRUCTION_EN
  logic          Obstructed;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  // Model state.
  int m_state;
  int m_pos;
  int m_cnt;
  bit m_obs;

  garage_door_actuator #(
    .TRAVEL_CYCLES(TRAVEL),
    .SPIN_CYCLES  (SPIN),
    .POS_W        (PW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .UP_M      (UP_M),
    .DN_M      (DN_M),
`ifdef OBSTRUCTION_EN
    .Obstruct  (tb_obstruct),
    .Obstructed(Obstructed),
`endif
    .UP_Max    (UP_Max),
    .DN_Max    (DN_Max),
    .Position  (Position),
    .Moving    (Moving),
    .Fault     (Fault)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_STOP;
    m_pos   = 0;
    m_cnt   = 0;
    m_obs   = 1'b0;
  endtask

  // One clock of the reference behaviour for the given commands.
  task automatic model_step(input bit up, input bit dn, input bit obst);
    bit hit;
`ifdef OBSTRUCTION_EN
    hit = obst && !(up && dn) && (m_state == M_SD || m_state == M_MD);
`else
    hit = 1'b0;
    if (obst) hit = 1'b0;
`endif
    if (up && dn) begin
      m_state = M_FLT;
    end else if (m_state == M_FLT) begin
      if (!up && !dn) m_state = M_STOP;
    end else if (m_state == M_STOP) begin
      if (up && m_pos < int'(TRAVEL)) begin
        m_state = M_SU;
        m_cnt   = 0;
        m_obs   = 1'b0;
      end else if (dn && m_pos > 0) begin
`ifdef OBSTRUCTION_EN
        if (!obst) begin
          m_state = M_SD;
          m_cnt   = 0;
        end
`else
        m_state = M_SD;
        m_cnt   = 0;
`endif
      end
    end else if (m_state == M_SU || m_state == M_SD) begin
      bit keep;
      keep = (m_state == M_SU) ? (up && !dn) : (dn && !up);
      if (!keep || hit) begin
        m_state = M_STOP;
        if (hit) m_obs = 1'b1;
      end else if (m_cnt + 1 >= int'(SPIN)) begin
        m_state = (m_state == M_SU) ? M_MU : M_MD;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else if (m_state == M_MU) begin
      if (!(up && !dn)) begin
        m_state = M_STOP;
      end else begin
        m_pos = m_pos + 1;
        if (m_pos >= int'(TRAVEL)) begin
          m_pos   = TRAVEL;
          m_state = M_STOP;
        end
      end
    end else if (m_state == M_MD) begin
      if (!(dn && !up) || hit) begin
        m_state = M_STOP;
        if (hit) m_obs = 1'b1;
      end else begin
        m_pos = m_pos - 1;
        if (m_pos <= 0) begin
          m_pos   = 0;
          m_state = M_STOP;
        end
      end
    end
  endtask

  // Drive one cycle of commands, predict, then compare after the edge.
  task automatic drive(input bit up, input bit dn);
    exp_t e;
    exp_t got;
    UP_M = up;
    DN_M = dn;
    model_step(up, dn, tb_obstruct);
    e.pos    = PW'(m_pos);
    e.up_max = (m_pos == int'(TRAVEL));
    e.dn_max = (m_pos == 0);
    e.moving = (m_state == M_MU) || (m_state == M_MD);
    e.fault  = (m_state == M_FLT);
    e.obs    = m_obs;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check("sb_pos", 32'(Position), 32'(got.pos));
      check("sb_up_max", 32'(UP_Max), 32'(got.up_max));
      check("sb_dn_max", 32'(DN_Max), 32'(got.dn_max));
      check("sb_moving", 32'(Moving), 32'(got.moving));
      check("sb_fault", 32'(Fault), 32'(got.fault));
`ifdef OBSTRUCTION_EN
      check("sb_obstructed", 32'(Obstructed), 32'(got.obs));
`endif
    end
  endtask

  task automatic drive_n(input bit up, input bit dn, input int n);
    for (int i = 0; i < n; i++) drive(up, dn);
  endtask

  initial begin
    RST         = 1'b1;
    UP_M        = 1'b0;
    DN_M        = 1'b0;
    tb_obstruct = 1'b0;
    model_reset();

    // Reset values while RST is held.
    repeat (2) @(posedge CLK);
    #1;
    check("rst_pos", 32'(Position), 32'd0);
    check("rst_dn_max", 32'(DN_Max), 32'd1);
    check("rst_up_max", 32'(UP_Max), 32'd0);
    check("rst_moving", 32'(Moving), 32'd0);
    check("rst_fault", 32'(Fault), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Idle after reset.
    drive_n(1'b0, 1'b0, 5);
    check("idle_pos", 32'(Position), 32'd0);
    check("idle_dn_max", 32'(DN_Max), 32'd1);

    // Full open with the default timing.
    for (int i = 1; i <= 11; i++) begin
      drive(1'b1, 1'b0);
      if (i == 3) check("open_dn_max_e3", 32'(DN_Max), 32'd1);
      if (i == 4) check("open_dn_max_e4", 32'(DN_Max), 32'd0);
      if (i == 10) check("open_up_max_e10", 32'(UP_Max), 32'd0);
      if (i == 11) begin
        check("open_up_max_e11", 32'(UP_Max), 32'd1);
        check("open_pos_e11", 32'(Position), 32'd8);
        check("open_moving_e11", 32'(Moving), 32'd0);
      end
    end
    drive_n(1'b1, 1'b0, 3);
    check("open_saturate", 32'(Position), 32'd8);
    drive(1'b0, 1'b0);

    // Full close, then a further close command is ignored.
    for (int i = 1; i <= 11; i++) begin
      drive(1'b0, 1'b1);
      if (i == 11) begin
        check("close_pos_e11", 32'(Position), 32'd0);
        check("close_dn_max_e11", 32'(DN_Max), 32'd1);
      end
    end
    drive_n(1'b0, 1'b1, 4);
    check("close_no_move", 32'(Position), 32'd0);
    check("close_no_moving", 32'(Moving), 32'd0);
    drive(1'b0, 1'b0);

    // Mid-travel stop at position 3, then fault and recovery.
    drive_n(1'b1, 1'b0, 6);
    check("mid_pos3", 32'(Position), 32'd3);
    drive_n(1'b0, 1'b0, 2);
    check("mid_hold", 32'(Position), 32'd3);
    check("mid_up_max", 32'(UP_Max), 32'd0);
    check("mid_dn_max", 32'(DN_Max), 32'd0);
    drive(1'b1, 1'b1);
    check("fault_set", 32'(Fault), 32'd1);
    drive(1'b1, 1'b0);
    check("fault_hold", 32'(Fault), 32'd1);
    drive(1'b0, 1'b0);
    check("fault_clear", 32'(Fault), 32'd0);
    check("fault_pos", 32'(Position), 32'd3);

    // Reversal while moving stops first; spin drop returns to stopped.
    drive_n(1'b1, 1'b0, 4);
    drive(1'b0, 1'b1);
    check("rev_pos", 32'(Position), 32'd4);
    check("rev_moving", 32'(Moving), 32'd0);
    drive_n(1'b0, 1'b1, 3);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    check("spin_drop_pos", 32'(Position), 32'd4);

    // Reset mid-travel acts without a clock edge.
    drive_n(1'b1, 1'b0, 4);
    check("pre_rst_pos5", 32'(Position), 32'd5);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_pos", 32'(Position), 32'd0);
    check("async_rst_dn_max", 32'(DN_Max), 32'd1);
    check("async_rst_moving", 32'(Moving), 32'd0);
    model_reset();
    #2;
    RST = 1'b0;
    drive_n(1'b1, 1'b0, 4);
    check("post_rst_pos", 32'(Position), 32'd1);

    // Random command runs against the model.
    for (int r = 0; r < 40; r++) begin
      int sel;
      int len;
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 12);
      if (sel < 4) drive_n(1'b1, 1'b0, len);
      else if (sel < 8) drive_n(1'b0, 1'b1, len);
      else if (sel == 8) drive_n(1'b0, 1'b0, len);
      else drive_n(1'b1, 1'b1, 1);
    end

`ifdef OBSTRUCTION_EN
    // Close fully, open fully, then obstruct while closing at position 4.
    drive(1'b0, 1'b0);
    drive_n(1'b0, 1'b1, 14);
    drive(1'b0, 1'b0);
    drive_n(1'b1, 1'b0, 11);
    drive(1'b0, 1'b0);
    drive_n(1'b0, 1'b1, 7);
    check("obs_pre_pos4", 32'(Position), 32'd4);
    tb_obstruct = 1'b1;
    drive(1'b0, 1'b1);
    check("obs_pos_held", 32'(Position), 32'd4);
    check("obs_flag_set", 32'(Obstructed), 32'd1);
    drive_n(1'b0, 1'b1, 3);
    check("obs_dn_ignored", 32'(Position), 32'd4);
    tb_obstruct = 1'b0;
    drive(1'b1, 1'b0);
    check("obs_flag_clear", 32'(Obstructed), 32'd0);
`endif

    if (sb_q.size() != 0) check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/garage_door_actuator.md
GARAGE_DOOR_ACTUATOR -- requirements
Module: garage_door_actuator

Interface
REQ-001 The clock SHALL be CLK (single clock, all state on its rising edge), and the reset SHALL be RST (asynchronous, active-high).
REQ-002 Parameter TRAVEL_CYCLES, default 8, SHALL set the number of movement steps between the fully-closed and fully-open positions (legal range 1..2^POS_W-1).
REQ-003 Parameter SPIN_CYCLES, default 2, SHALL set the motor spin-up delay in cycles before the door moves (legal range >=1).
REQ-004 Parameter POS_W, default 8, SHALL set the position width.
REQ-005 CLK  input  1  clock.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 UP_M  input  1  motor up command.
REQ-008 DN_M  input  1  motor down command.
REQ-009 UP_Max  output  1  upper limit switch; 1 iff Position==TRAVEL_CYCLES.
REQ-010 DN_Max  output  1  lower limit switch; 1 iff Position==0.
REQ-011 Position  output  POS_W  current door position; 0 is closed.
REQ-012 Moving  output  1  1 iff the state is MOVE_UP or MOVE_DN.
REQ-013 Fault  output  1  1 iff the state is FAULT.

Function
REQ-014 The FSM SHALL have the states STOPPED, SPIN_UP, SPIN_DN, MOVE_UP, MOVE_DN and FAULT, and all outputs SHALL be registered.
REQ-015 From any state, a sampled UP_M=1 together with DN_M=1 SHALL cause a transition to FAULT with Position held.
REQ-016 FAULT SHALL stay in FAULT while either command is 1, and SHALL go to STOPPED on the first edge at which both commands are 0.
REQ-017 STOPPED with UP_M only and Position<TRAVEL_CYCLES SHALL go to SPIN_UP with the spin counter cleared; a command toward a limit already reached SHALL be ignored.
REQ-018 STOPPED with DN_M only and Position>0 SHALL go to SPIN_DN with the spin counter cleared.
REQ-019 SPIN_x SHALL go to MOVE_x when spin_cnt==SPIN_CYCLES-1 and SHALL otherwise increment spin_cnt; dropping the command SHALL return the FSM to STOPPED.
REQ-020 MOVE_UP SHALL increment Position by 1 per cycle, and SHALL go to STOPPED on the edge at which Position becomes TRAVEL_CYCLES.
REQ-021 MOVE_DN SHALL decrement Position by 1 per cycle, and SHALL go to STOPPED on the edge at which Position becomes 0.
REQ-022 Position SHALL saturate, never exceeding TRAVEL_CYCLES and never wrapping below 0.
REQ-023 Dropping the command in MOVE_x SHALL move the FSM to STOPPED with Position held mid-travel and both UP_Max and DN_Max at 0.
REQ-024 A reversed command (the opposite command alone) in SPIN_x or MOVE_x SHALL go to STOPPED first, never directly to the opposite spin state.
REQ-025 UP_Max and DN_Max SHALL be computed from the next Position value, so each changes on the same edge as Position.
REQ-026 Latency: with UP_M held from first-sample edge 1, UP_Max SHALL rise on edge 1+SPIN_CYCLES+TRAVEL_CYCLES, and DN_Max SHALL fall on edge 2+SPIN_CYCLES.

Reset
REQ-027 Reset SHALL asynchronously force state=STOPPED, Position=0, spin_cnt=0, DN_Max=1, UP_Max=0, Moving=0 and Fault=0, so that reset mid-travel returns the door to closed.
REQ-028 On the first edge after RST deasserts, the commands SHALL be evaluated from STOPPED.

Configuration
REQ-029 With OBSTRUCTION_EN defined, the block SHALL add input Obstruct (1 bit) and output Obstructed (1 bit).
REQ-030 With OBSTRUCTION_EN defined, Obstruct=1 sampled in MOVE_DN or SPIN_DN SHALL force STOPPED with Position held and set Obstructed.
REQ-031 Obstructed SHALL be sticky, clearing only on entry to SPIN_UP or on reset.
REQ-032 With OBSTRUCTION_EN defined, DN_M SHALL be ignored in STOPPED while Obstruct=1.
REQ-033 Without OBSTRUCTION_EN, neither the Obstruct nor the Obstructed port SHALL exist, and the behaviour SHALL be exactly as specified above.

Verification
REQ-034 Reset then idle: RST pulse, commands 0 for 5 cycles -> Position=0, DN_Max=1, UP_Max=0, Moving=0, Fault=0.
REQ-035 Full open (defaults): UP_M held -> DN_Max=0 after edge 4, UP_Max=1 and Position=8 after edge 11, Moving=0 after edge 11.
REQ-036 Full close: from open, DN_M held -> DN_Max=1 and Position=0 after edge 11; a further DN_M produces no movement.
REQ-037 Mid-travel stop and fault: UP_M dropped at Position=3 -> Position stays 3 with both limits 0; UP_M=DN_M=1 -> Fault=1; both 0 -> Fault=0.
REQ-038 Reset mid-travel: RST asserted at Position=5 -> Position=0 and DN_Max=1 immediately, without waiting for a clock edge.
REQ-039 OBSTRUCTION_EN: closing, Obstruct=1 at Position=4 -> Position held at 4 and Obstructed=1; UP_M -> Obstructed=0 on entry to SPIN_UP.
